gmii_mdio_master: RTL and testbench
===================================

// Module: gmii_mdio_master
// PURPOSE
//  MAC-side MDIO station-management initiator. It serialises Clause-22 read and write
//  frames onto sig_MDCLK / sig_MDIO toward the GMII PHY's management responder.
//  It accepts one register request at a time from the MAC control/CSR logic and
//  returns read data. It sits beside the GMII datapath and is the management
//  master for the PHY on the bench.
// PARAMETERS
//  CLK_DIV  10  sig_MDCLK half-period, in sig_CLK cycles (legal range 2..255)
//  PRE_LEN  32  preamble length, in bits of '1' (legal range 0..32)
// PORTS
//  sig_CLK       in     1   system clock; the single clock of the block
//  sig_RESET     in     1   asynchronous, active-high reset
//  req_valid     in     1   request present
//  req_ready     out    1   block idle, able to accept a request
//  req_read      in     1   1 = read (OP=10), 0 = write (OP=01)
//  req_phy_addr  in     5   PHYAD field
//  req_reg_addr  in     5   REGAD field
//  req_wdata     in    16   write data (ignored on a read)
//  rsp_valid     out    1   one-cycle pulse: transaction complete
//  rsp_rdata     out   16   read data; held until the next read completes
//  rsp_err       out    1   read turnaround error; qualified by rsp_valid
//  sig_MDCLK     out    1   management clock
//  sig_MDIO      inout  1   management data; tri-stated when not driven
// BEHAVIOUR
//  Reset:
//   - State IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
//   - sig_MDCLK=0; sig_MDIO output enable=0 (sig_MDIO is Z).
//  Handshake:
//   - A request is accepted in the cycle where req_valid && req_ready.
//   - All request fields are registered in that cycle.
//   - req_ready=0 from the following cycle until the cycle after rsp_valid.
//  Bit timing:
//   - Each frame bit is one sig_MDCLK period of 2*CLK_DIV cycles: CLK_DIV cycles low,
//     then CLK_DIV cycles high.
//   - The master updates its sig_MDIO drive on the cycle sig_MDCLK goes low.
//   - The master samples sig_MDIO on the cycle sig_MDCLK goes high.
//   - sig_MDCLK stays 0 while IDLE; there is no free-running clock.
//  Frame sequence, MSB first, states PRE -> ST -> OP -> PHYAD -> REGAD -> TA -> DATA -> DONE:
//   - PRE: PRE_LEN ones. PRE_LEN=0 skips PRE and goes directly to ST.
//   - ST: '01'.
//   - OP: '10' for a read, '01' for a write.
//   - PHYAD: 5 bits. REGAD: 5 bits.
//   - TA, write: the master drives '10'.
//   - TA, read: the master releases sig_MDIO for both TA bits.
//     - The second TA bit is sampled.
//     - If it is not 0, rsp_err=1. The frame still completes.
//   - DATA: 16 bits.
//     - Write: driven from req_wdata.
//     - Read: the master stays released; bits are shifted into rsp_rdata on each
//       sig_MDCLK rise.
//   - DONE: sig_MDIO is released at the end of the last high phase and
//     rsp_valid=1 for one cycle, then IDLE.
//  Latency:
//   - rsp_valid asserts exactly (PRE_LEN+32)*2*CLK_DIV cycles after the acceptance cycle.
//   - With the defaults this is 1280 cycles.
//  Outputs on writes:
//   - rsp_err=0.
//   - rsp_rdata is unchanged.
//  Counters:
//   - Bit counter: 6 bits. Divider counter: 8 bits. Both wrap to 0 at each phase
//     or state boundary. Neither ever free-runs.
//  Asynchronous reset mid-frame:
//   - Force the reset values immediately: sig_MDCLK=0, sig_MDIO=Z.
//   - The transaction is abandoned and no rsp_valid is issued.
//   - req_valid held through reset is accepted on the first cycle after reset
//     deasserts.
//  Back-to-back requests:
//   - The earliest next acceptance is the cycle after rsp_valid.
//   - Consecutive frames are separated by at least 1 idle sig_CLK cycle.
// TESTING (CLK_DIV=10, PRE_LEN=32, GMII PHY model on sig_MDCLK/sig_MDIO, 1k pull-up)
//  1. Write PHY 1, REG 0, 0x1140
//     -> wire shows 32x'1', 0101, 00001, 00000, 10, 0001000101000000;
//        rsp_valid at cycle +1280; rsp_err=0.
//  2. Read PHY 1, REG 2 with the model returning 0x0141
//     -> the master drives nothing from TA bit 1 onward;
//        rsp_rdata=0x0141; rsp_err=0; rsp_valid at +1280.
//  3. Read PHY 31 (absent; pull-up only)
//     -> rsp_rdata=0xFFFF; rsp_err=1; rsp_valid still at +1280.
//  4. req_valid held high for two writes
//     -> req_ready=0 during the frame; second acceptance at the cycle after
//        the first rsp_valid; both frames are bit-exact.
//  5. Assert sig_RESET at cycle 400 of a write
//     -> same-cycle sig_MDCLK=0, sig_MDIO=Z, no rsp_valid;
//        a new read after release completes normally.
//  6. PRE_LEN=0, CLK_DIV=2 read
//     -> frame starts directly with ST;
//        rsp_valid at (0+32)*2*2=128 cycles after acceptance.

Source files
------------

// File: rtl/gmii_mdio_master.sv
// Clause-22 MDIO management master: serialises one read/write frame per
// request onto MDC/MDIO and returns read data with a turnaround error flag.
module gmii_mdio_master #(
    parameter int unsigned CLK_DIV = 10,
    parameter int unsigned PRE_LEN = 32
) (
    input  logic        sig_CLK,
    input  logic        sig_RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [4:0]  req_phy_addr,
    input  logic [4:0]  req_reg_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        sig_MDCLK,
    inout  wire         sig_MDIO
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);

    state_t      state_q, state_d, nxt_state;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d, last_bit;
    logic        mdc_q, mdc_d;
    logic        oe_q, oe_d;
    logic        rd_q, rd_d;
    logic [31:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic        mdo;
    logic        mdio_in;

    // Preamble bits are constant ones; every later field comes from tx_q.
    assign mdo       = (state_q == S_PRE) ? 1'b1 : tx_q[31];
    assign sig_MDIO  = oe_q ? mdo : 1'bz;
    assign mdio_in   = sig_MDIO;
    assign sig_MDCLK = mdc_q;
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Field length and successor state of the current frame field.
    always_comb begin
        last_bit  = 6'd1;
        nxt_state = S_DONE;
        unique case (state_q)
            S_PRE:  begin last_bit = PRE_LAST; nxt_state = S_ST;   end
            S_ST:   nxt_state = S_OP;
            S_OP:   nxt_state = S_PHY;
            S_PHY:  begin last_bit = 6'd4;     nxt_state = S_REG;  end
            S_REG:  begin last_bit = 6'd4;     nxt_state = S_TA;   end
            S_TA:   nxt_state = S_DATA;
            S_DATA: begin last_bit = 6'd15;    nxt_state = S_DONE; end
            default: ;
        endcase
    end

    // Next-state: request capture, MDC phase timing, bit shifting, sampling.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        mdc_d   = mdc_q;
        oe_d    = oe_q;
        rd_d    = rd_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rd_d    = req_read;
                    tx_d    = {2'b01,
                               req_read ? 2'b10 : 2'b01,
                               req_phy_addr, req_reg_addr,
                               req_read ? 2'b11 : 2'b10,
                               req_read ? 16'h0000 : req_wdata};
                    err_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    mdc_d   = 1'b0;
                    oe_d    = 1'b1;
                    state_d = (PRE_LEN == 0) ? S_ST : S_PRE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    if (!mdc_q) begin
                        mdc_d = 1'b1;
                        if (state_q == S_TA && bit_q == 6'd1 && rd_q)
                            err_d = mdio_in;
                        if (state_q == S_DATA && rd_q)
                            rx_d = {rx_q[14:0], mdio_in};
                    end else begin
                        mdc_d = 1'b0;
                        if (state_q != S_PRE)
                            tx_d = {tx_q[30:0], 1'b0};
                        if (bit_q == last_bit) begin
                            bit_d   = '0;
                            state_d = nxt_state;
                            if (nxt_state == S_TA && rd_q)
                                oe_d = 1'b0;
                            if (nxt_state == S_DONE) begin
                                oe_d    = 1'b0;
                                valid_d = 1'b1;
                                if (rd_q)
                                    rdata_d = rx_q;
                            end
                        end else begin
                            bit_d = bit_q + 6'd1;
                        end
                    end
                end
            end
        endcase
    end

    // State and datapath registers; reset releases MDIO and stops MDC at once.
    always_ff @(posedge sig_CLK or posedge sig_RESET) begin
        if (sig_RESET) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            mdc_q   <= 1'b0;
            oe_q    <= 1'b0;
            rd_q    <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            mdc_q   <= mdc_d;
            oe_q    <= oe_d;
            rd_q    <= rd_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_gmii_mdio_master.sv
// Bench for gmii_mdio_master: two instances (default and PRE_LEN=0/CLK_DIV=2),
// a simple PHY model on each MDIO wire, and a response scoreboard.
module tb_gmii_mdio_master;

    typedef struct {
        bit          sel;
        bit          rd;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wdata;
        bit          present;
        logic [15:0] prd;
        logic [15:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        bit          err;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_read = 1'b0;
    logic [4:0]  req_phy = '0;
    logic [4:0]  req_reg = '0;
    logic [15:0] req_wdata = '0;
    logic        phy_oe = 1'b0;
    logic        phy_do = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          tmo = 1'b0;
    exp_t        sb[$];

    wire        rdy_a, rdy_b, rv_a, rv_b, err_a, err_b, mdc_a, mdc_b;
    wire [15:0] rd_a, rd_b;
    wire        mdio_a, mdio_b;

    pullup (mdio_a);
    pullup (mdio_b);
    assign mdio_a = (phy_oe && !sel) ? phy_do : 1'bz;
    assign mdio_b = (phy_oe && sel) ? phy_do : 1'bz;

    wire        mdc_m  = sel ? mdc_b : mdc_a;
    wire        mdio_m = sel ? mdio_b : mdio_a;
    wire        rdy_m  = sel ? rdy_b : rdy_a;
    wire        rv_m   = sel ? rv_b : rv_a;
    wire        err_m  = sel ? err_b : err_a;
    wire [15:0] rd_m   = sel ? rd_b : rd_a;

    gmii_mdio_master u_dut_a (
        .sig_CLK(clk), .sig_RESET(rst),
        .req_valid(req_valid && !sel), .req_ready(rdy_a),
        .req_read(req_read), .req_phy_addr(req_phy),
        .req_reg_addr(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a),
        .sig_MDCLK(mdc_a), .sig_MDIO(mdio_a)
    );

    gmii_mdio_master #(.CLK_DIV(2), .PRE_LEN(0)) u_dut_b (
        .sig_CLK(clk), .sig_RESET(rst),
        .req_valid(req_valid && sel), .req_ready(rdy_b),
        .req_read(req_read), .req_phy_addr(req_phy),
        .req_reg_addr(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b),
        .sig_MDCLK(mdc_b), .sig_MDIO(mdio_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rv_m) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rd_m, e.rdata);
                chk("rsp_err", err_m, e.err);
                chk("rsp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic wait_mdc(input logic level);
        int n = 0;
        while (mdc_m !== level && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            tmo = 1'b1;
            chk("mdc_timeout", 1, 0);
        end
    endtask

    task automatic do_req(input vec_t v, input bit keep,
                          output int acc, output int waits);
        int n = 0;
        exp_t e;
        sel = v.sel;
        req_read = v.rd;
        req_phy = v.phy;
        req_reg = v.rg;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        #1;
        while (!rdy_m && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("ready_timeout", 1, 0);
        acc = cyc + 1;
        waits = n;
        e.rdata = v.exp_rdata;
        e.err = v.exp_err;
        e.acc = acc;
        e.lat = v.sel ? (0 + 32) * 2 * 2 : (32 + 32) * 2 * 10;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        bit e[64];
        bit en[64];
        bit val[64];
        int pre = v.sel ? 0 : 32;
        int nb = pre + 32;
        int k = 0;
        int bad = -1;
        logic [13:0] hdr;
        logic [17:0] tail;
        for (int i = 0; i < 64; i++) begin
            e[i] = 1'b1; en[i] = 1'b0; val[i] = 1'b0;
        end
        k = pre;
        hdr = {2'b01, v.rd ? 2'b10 : 2'b01, v.phy, v.rg};
        for (int i = 13; i >= 0; i--) begin e[k] = hdr[i]; k++; end
        if (!v.rd) begin
            tail = {2'b10, v.wdata};
            for (int i = 17; i >= 0; i--) begin e[k] = tail[i]; k++; end
        end else begin
            k++;
            tail = {2'b00, v.prd};
            for (int i = 16; i >= 0; i--) begin
                en[k] = v.present;
                val[k] = tail[i];
                e[k] = v.present ? tail[i] : 1'b1;
                k++;
            end
        end
        tmo = 1'b0;
        for (int i = 0; i < nb; i++) begin
            phy_oe = en[i];
            phy_do = val[i];
            wait_mdc(1'b1);
            if (tmo) break;
            if (mdio_m !== e[i] && bad < 0) bad = i;
            wait_mdc(1'b0);
            if (tmo) break;
        end
        phy_oe = 1'b0;
        chk("frame_first_bad_bit", bad, -1);
    endtask

    task automatic wait_sb_empty();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_pending", sb.size(), 0);
    endtask

    vec_t vt[7];
    vec_t w1, w2, w3, r4;
    int   a1, a2, a3, a4, wt, rel;

    initial begin
        vt[0] = '{0, 0, 5'd1,  5'd0,  16'h1140, 0, 16'h0000, 16'h0000, 0};
        vt[1] = '{0, 1, 5'd1,  5'd2,  16'h0000, 1, 16'h0141, 16'h0141, 0};
        vt[2] = '{0, 1, 5'd31, 5'd2,  16'h0000, 0, 16'h0000, 16'hFFFF, 1};
        vt[3] = '{0, 0, 5'd5,  5'd27, 16'hA5C3, 0, 16'h0000, 16'hFFFF, 0};
        vt[4] = '{0, 1, 5'd3,  5'd4,  16'h0000, 1, 16'h8001, 16'h8001, 0};
        vt[5] = '{1, 1, 5'd1,  5'd2,  16'h0000, 1, 16'h5AA5, 16'h5AA5, 0};
        vt[6] = '{1, 0, 5'd2,  5'd9,  16'h00FF, 0, 16'h0000, 16'h5AA5, 0};
        w1    = '{0, 0, 5'd1,  5'd0,  16'h1140, 0, 16'h0000, 16'h8001, 0};
        w2    = '{0, 0, 5'd1,  5'd4,  16'h0DEF, 0, 16'h0000, 16'h8001, 0};
        w3    = '{0, 0, 5'd1,  5'd0,  16'h1234, 0, 16'h0000, 16'h0000, 0};
        r4    = '{0, 1, 5'd1,  5'd2,  16'h0000, 1, 16'h0141, 16'h0141, 0};

        repeat (3) @(negedge clk);
        chk("reset_ready", rdy_a, 1);
        chk("reset_rsp_valid", rv_a, 0);
        chk("reset_rdata", rd_a, 0);
        chk("reset_err", err_a, 0);
        chk("reset_mdc", mdc_a, 0);
        chk("reset_mdio_released", mdio_a, 1);
        chk("reset_ready_b", rdy_b, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_mdc_still", mdc_a, 0);

        for (int i = 0; i < 7; i++) begin
            fork
                do_req(vt[i], 1'b0, a1, wt);
                run_frame(vt[i]);
            join
            wait_sb_empty();
            @(negedge clk);
        end

        fork
            begin
                do_req(w1, 1'b1, a1, wt);
                @(negedge clk);
                do_req(w2, 1'b0, a2, wt);
            end
            begin
                run_frame(w1);
                run_frame(w2);
            end
        join
        wait_sb_empty();
        chk("b2b_ready_low_cycles", wt, 1281);
        chk("b2b_accept_gap", a2 - a1, 1282);
        @(negedge clk);

        do_req(w3, 1'b0, a3, wt);
        while (cyc < a3 + 410) @(negedge clk);
        chk("mid_frame_mdc_high", mdc_a, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_mdc", mdc_a, 0);
        chk("async_reset_rsp_valid", rv_a, 0);
        chk("async_reset_ready", rdy_a, 1);
        phy_oe = 1'b1;
        phy_do = 1'b0;
        #1;
        chk("async_reset_mdio_released", mdio_a, 0);
        phy_oe = 1'b0;
        sb.delete();
        sel = 1'b0;
        req_read = 1'b1;
        req_phy = 5'd1;
        req_reg = 5'd2;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        fork
            do_req(r4, 1'b0, a4, wt);
            run_frame(r4);
        join
        wait_sb_empty();
        chk("accept_after_reset", a4 - rel, 1);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
